// File: rtl/mips_controller.sv
// Main control FSM for the multicycle 32-bit MIPS core.
// Sequences fetch, decode, execute, memory and writeback. Every datapath
// select and enable is decoded from the current state. The one exception is
// pc_write_en in BRANCH, which follows the ALU's branch_taken flag.
//
// Handshake: none. The controller free-runs one state per clock and assumes
// the datapath and memory finish each step in one cycle. Memory reads are
// synchronous: the address is presented in one cycle and the data is taken
// in the next.
//
// Load timing: the load spends one cycle presenting the address (MEM_RD).
// The writeback cycle (MEM_WB) keeps i_or_d=1 so that the address stays
// stable while the returned data is written. This gives lw its six-cycle
// cost and keeps the state set at exactly sixteen 4-bit encodings.
//
// Debug visibility: the current state is held in the enum signal `state`.
module mips_controller #(
    parameter int unsigned      OPC_W    = 6,
    parameter logic [OPC_W-1:0] HALT_OPC = 6'h3F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    input  logic             branch_taken,
    output logic             pc_write_en,
    output logic             i_or_d,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic             alu_op,
    output logic             jump_and_link,
    output logic             is_signed,
    output logic             halted
);

    // Opcode and funct values the dispatcher recognises.
    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'('h00);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'('h02);
    localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'('h03);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'('h04);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'('h05);
    localparam logic [OPC_W-1:0] OP_ADDIU = OPC_W'('h09);
    localparam logic [OPC_W-1:0] OP_ANDI  = OPC_W'('h0C);
    localparam logic [OPC_W-1:0] OP_ORI   = OPC_W'('h0D);
    localparam logic [OPC_W-1:0] OP_XORI  = OPC_W'('h0E);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'('h23);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'('h2B);
    localparam logic [OPC_W-1:0] FN_JR    = OPC_W'('h08);

    // ALU B operand selects.
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC selects.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_DECODE     = 4'd2,
        S_R_EXEC     = 4'd3,
        S_R_WB       = 4'd4,
        S_I_EXEC     = 4'd5,
        S_I_WB       = 4'd6,
        S_MEM_ADDR   = 4'd7,
        S_MEM_RD     = 4'd8,
        S_MEM_WB     = 4'd9,
        S_MEM_WR     = 4'd10,
        S_BRANCH     = 4'd11,
        S_JUMP       = 4'd12,
        S_JAL        = 4'd13,
        S_JR         = 4'd14,
        S_HALT       = 4'd15
    } state_t;

    state_t state;

    // The immediate class is captured in DECODE so that later changes to the
    // opcode field cannot alter the extension mode used in I_EXEC.
    logic imm_zero_ext;

    // Decode-time classification of the opcode field.
    logic is_logical_imm;
    logic is_arith_imm;
    assign is_logical_imm = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    assign is_arith_imm   = (opcode >= OP_ADDIU) && (opcode < OP_ANDI);

    // State register and next-state logic; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_FETCH;
            imm_zero_ext <= 1'b0;
        end else begin
            case (state)
                S_FETCH:      state <= S_FETCH_WAIT;
                S_FETCH_WAIT: state <= S_DECODE;
                S_DECODE: begin
                    imm_zero_ext <= is_logical_imm;
                    if (opcode == HALT_OPC) begin
                        state <= S_HALT;
                    end else if (opcode == OP_RTYPE) begin
                        state <= (funct == FN_JR) ? S_JR : S_R_EXEC;
                    end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                        state <= S_MEM_ADDR;
                    end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
                        state <= S_BRANCH;
                    end else if (opcode == OP_J) begin
                        state <= S_JUMP;
                    end else if (opcode == OP_JAL) begin
                        state <= S_JAL;
                    end else if (is_arith_imm || is_logical_imm) begin
                        state <= S_I_EXEC;
                    end else begin
                        // Unknown opcodes retire as a NOP.
                        state <= S_FETCH;
                    end
                end
                S_R_EXEC:   state <= S_R_WB;
                S_R_WB:     state <= S_FETCH;
                S_I_EXEC:   state <= S_I_WB;
                S_I_WB:     state <= S_FETCH;
                S_MEM_ADDR: begin
                    if (opcode == OP_LW) begin
                        state <= S_MEM_RD;
                    end else if (opcode == OP_SW) begin
                        state <= S_MEM_WR;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_MEM_RD:   state <= S_MEM_WB;
                S_MEM_WB:   state <= S_FETCH;
                S_MEM_WR:   state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JUMP:     state <= S_FETCH;
                S_JAL:      state <= S_FETCH;
                S_JR:       state <= S_FETCH;
                S_HALT:     state <= S_HALT;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode, forced to all-zero while reset is held low.
    always_comb begin
        pc_write_en   = 1'b0;
        i_or_d        = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        alu_op        = 1'b0;
        jump_and_link = 1'b0;
        is_signed     = 1'b0;
        halted        = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    // PC <- PC + 4 while the instruction memory read starts.
                    alu_src_b   = SRCB_FOUR;
                    pc_source   = PCSRC_ALU;
                    pc_write_en = 1'b1;
                end
                S_FETCH_WAIT: begin
                    ir_write = 1'b1;
                end
                S_DECODE: begin
                    // Precompute the branch target into ALU_OUT.
                    alu_src_b = SRCB_IMMSH;
                    is_signed = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_REG;
                    alu_op    = 1'b1;
                end
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = 1'b1;
                    is_signed = ~imm_zero_ext;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    is_signed = 1'b1;
                end
                S_MEM_RD: begin
                    i_or_d = 1'b1;
                end
                S_MEM_WB: begin
                    i_or_d     = 1'b1;
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEM_WR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = SRCB_REG;
                    alu_op      = 1'b1;
                    pc_source   = PCSRC_ALUOUT;
                    pc_write_en = branch_taken;
                end
                S_JUMP: begin
                    pc_source   = PCSRC_JUMP;
                    pc_write_en = 1'b1;
                end
                S_JAL: begin
                    pc_source     = PCSRC_JUMP;
                    pc_write_en   = 1'b1;
                    jump_and_link = 1'b1;
                    reg_write     = 1'b1;
                end
                S_JR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = SRCB_REG;
                    alu_op      = 1'b1;
                    pc_source   = PCSRC_ALU;
                    pc_write_en = 1'b1;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
